display_stream_arbiter: RTL and testbench

//  Shares the single Avalon-ST display sink (16-bit data, valid/ready, ready = slow pulse)

---
 rtl/display_stream_arbiter.sv | 136 +++++++++++++
 tb/tb_display_stream_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/display_stream_arbiter.sv
// Round-robin arbiter sharing one Avalon-ST display sink between NUM_SRC producers.
// Each granted beat is held in a one-entry output register until accepted or timed out.
module display_stream_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int SRC_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk_hifreq,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] s_data,
  input  logic [NUM_SRC-1:0]        s_valid,
  output logic [NUM_SRC-1:0]        s_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [SRC_W-1:0]          m_src,
  input  logic                      lock_en,
  input  logic [SRC_W-1:0]          lock_sel,
  output logic [15:0]               beat_count,
  output logic                      drop_pulse,
  output logic                      busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE = 1'b0, LOADED = 1'b1} state_t;

  state_t             state_q;
  logic [SRC_W-1:0]   rr_ptr_q;
  logic [SRC_W-1:0]   rr_ptr_d;
  logic [DATA_W-1:0]  m_data_q;
  logic [SRC_W-1:0]   m_src_q;
  logic               m_valid_q;
  logic [15:0]        beat_count_q;
  logic               drop_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NUM_SRC-1:0] elig;
  logic               win_found;
  logic [SRC_W-1:0]   win_idx;
  logic [DATA_W-1:0]  win_data;
  logic [SRC_W-1:0]   scan_idx;
  int                 scan_sum;

  // An out-of-range lock_sel matches no source, so nothing is eligible.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = s_valid[i] & (~lock_en | (lock_sel == SRC_W'(i)));
    end
  end

  // Scan from the highest offset down so the source nearest rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    scan_sum  = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      scan_sum = int'(rr_ptr_q) + k;
      if (scan_sum >= NUM_SRC) scan_sum = scan_sum - NUM_SRC;
      scan_idx = SRC_W'(scan_sum);
      if (elig[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_idx == SRC_W'(i)) win_data = s_data[i*DATA_W +: DATA_W];
    end
  end

  assign rr_ptr_d = (win_idx == SRC_W'(NUM_SRC - 1)) ? '0 : win_idx + SRC_W'(1);

  always_comb begin
    s_ready = '0;
    if (!rst && state_q == IDLE && win_found) s_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge clk_hifreq) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_src_q      <= '0;
      beat_count_q <= '0;
      drop_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            m_data_q  <= win_data;
            m_src_q   <= win_idx;
            m_valid_q <= 1'b1;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= '0;
            state_q   <= LOADED;
          end
        end
        LOADED: begin
          // A sink accept on the expiry cycle takes priority over the drop.
          if (m_ready) begin
            m_valid_q    <= 1'b0;
            beat_count_q <= beat_count_q + 16'd1;
            state_q      <= IDLE;
          end else if (TO_EN && cnt_q == CNT_LAST) begin
            m_valid_q <= 1'b0;
            drop_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_data     = m_data_q;
  assign m_src      = m_src_q;
  assign m_valid    = m_valid_q;
  assign beat_count = beat_count_q;
  assign drop_pulse = drop_q;
  assign busy       = (state_q == LOADED);

endmodule

// File: tb/tb_display_stream_arbiter.sv
// Randomized scoreboard bench for display_stream_arbiter (5 sources, timeout 4).
module tb_display_stream_arbiter;

  localparam int N  = 5;
  localparam int DW = 16;
  localparam int T  = 4;
  localparam int SW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] src;
  } beat_t;

  logic            clk_hifreq = 1'b0;
  logic            rst        = 1'b1;
  logic [N*DW-1:0] s_data     = '0;
  logic [N-1:0]    s_valid    = '0;
  logic [N-1:0]    s_ready;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready    = 1'b0;
  logic [SW-1:0]   m_src;
  logic            lock_en    = 1'b0;
  logic [SW-1:0]   lock_sel   = '0;
  logic [15:0]     beat_count;
  logic            drop_pulse;
  logic            busy;

  display_stream_arbiter #(
    .NUM_SRC(N), .DATA_W(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_hifreq(clk_hifreq),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_src(m_src),
    .lock_en(lock_en),
    .lock_sel(lock_sel),
    .beat_count(beat_count),
    .drop_pulse(drop_pulse),
    .busy(busy)
  );

  always #5 clk_hifreq = ~clk_hifreq;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus knobs (percent, reset in per-mille)
  int unsigned src_prob  = 0;
  int unsigned rdy_prob  = 0;
  int unsigned rst_prob  = 0;
  int unsigned lock_prob = 0;
  logic [N-1:0] src_mask = '1;
  bit           force_rst = 1'b1;

  // Producers: a held beat stays put until the arbiter accepts it
  logic [N-1:0]  hold = '0;
  logic [DW-1:0] hdata [N];

  // Reference model: a pending slot, its age, a rotating pointer and a delivered count
  bit          mdl_busy  = 1'b0;
  int          mdl_age   = 0;
  int          mdl_rr    = 0;
  logic [15:0] mdl_count = '0;
  bit          mdl_drop  = 1'b0;
  bit          mdl_rst   = 1'b0;
  beat_t       exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy;
    int w;
    @(negedge clk_hifreq);
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && src_mask[i] && $urandom_range(99) < src_prob) begin
        hold[i]  = 1'b1;
        hdata[i] = DW'($urandom);
      end
    end
    s_valid = hold;
    for (int i = 0; i < N; i++) s_data[i*DW +: DW] = hdata[i];
    m_ready = ($urandom_range(99) < rdy_prob);
    rst     = force_rst || ($urandom_range(999) < rst_prob);
    if ($urandom_range(99) < lock_prob) lock_sel = SW'($urandom_range(7));
    #1;
    exp_rdy = '0;
    if (rst) begin
      mdl_busy  = 1'b0;
      mdl_age   = 0;
      mdl_rr    = 0;
      mdl_count = '0;
      mdl_drop  = 1'b0;
      mdl_rst   = 1'b1;
      exp_q.delete();
    end else begin
      mdl_rst  = 1'b0;
      mdl_drop = 1'b0;
      if (!mdl_busy) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (mdl_rr + k) % N;
          if (w < 0 && s_valid[SW'(idx)] && (!lock_en || int'(lock_sel) == idx)) w = idx;
        end
        if (w >= 0) begin
          exp_rdy = N'(1) << w;
          exp_q.push_back('{data: hdata[w], src: SW'(w)});
          mdl_busy = 1'b1;
          mdl_age  = 0;
          mdl_rr   = (w + 1) % N;
          hold[SW'(w)] = 1'b0;
        end
      end else if (m_ready) begin
        mdl_busy  = 1'b0;
        mdl_count = mdl_count + 16'd1;
      end else if (mdl_age == T - 1) begin
        mdl_busy = 1'b0;
        mdl_drop = 1'b1;
      end else begin
        mdl_age++;
      end
    end
    chk("s_ready", 32'(s_ready), 32'(exp_rdy));
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  // Monitor: checks registered outputs just after each edge and pops beats as they appear
  initial begin
    beat_t cur;
    logic  prev_v;
    cur    = '0;
    prev_v = 1'b0;
    forever begin
      @(posedge clk_hifreq);
      #1;
      chk("m_valid", 32'(m_valid), 32'(mdl_busy));
      chk("busy", 32'(busy), 32'(mdl_busy));
      chk("beat_count", 32'(beat_count), 32'(mdl_count));
      chk("drop_pulse", 32'(drop_pulse), 32'(mdl_drop));
      if (mdl_rst) begin
        chk("reset_m_data", 32'(m_data), 32'(0));
        chk("reset_m_src", 32'(m_src), 32'(0));
      end
      if (m_valid && !prev_v) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 32'(1), 32'(0));
        else cur = exp_q.pop_front();
      end
      if (m_valid) begin
        chk("m_data", 32'(m_data), 32'(cur.data));
        chk("m_src", 32'(m_src), 32'(cur.src));
      end
      prev_v = m_valid;
    end
  end

  initial begin
    // Reset held with every source requesting
    src_prob = 100; src_mask = '1; force_rst = 1'b1;
    run(3);
    // Round robin with an always-ready sink
    force_rst = 1'b0; rdy_prob = 100;
    run(25);
    // Single source into a slow sink, exercising timeouts and late accepts
    src_mask = 5'b00100; rdy_prob = 15;
    run(300);
    // Locked arbitration, lock_sel wandering over valid and out-of-range values
    src_mask = '1; src_prob = 60; rdy_prob = 40; lock_en = 1'b1; lock_sel = 3'd2; lock_prob = 10;
    run(500);
    // Fully random traffic with sporadic resets
    lock_en = 1'b0; src_prob = 50; rdy_prob = 30; rst_prob = 20;
    run(800);
    lock_en = 1'b1;
    run(400);
    // Reset while a beat is held
    lock_en = 1'b0; rst_prob = 0; src_prob = 100; rdy_prob = 0;
    run(3);
    force_rst = 1'b1;
    run(1);
    force_rst = 1'b0; rdy_prob = 50;
    run(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
